ram_dp: RTL and testbench

Parametrised dual-port synchronous RAM, successor to the 16-bit single-port `RAM`. Port A is read/write with byte-lane enables, and port B is read-only. Both ports have registered reads with a valid strobe. A built-in clear sequencer zeroes the whole array after every reset. The block sits between the CPU datapath (port A) and instruction fetch / debug readout (port B).

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_clear_seq.sv | 62 ++++++
 rtl/ram_dp.sv | 101 ++++++++++
 tb/tb_ram_dp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_dp dual-port RAM.
//   ram_state_t : clear sequencer states (CLEAR, READY)
//   lanes()     : number of byte lanes in a data word
//   ZERO_WORD   : all-zero word; slice to the width in use
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Widest word any instance is expected to use; ZERO_WORD is sliced down.
    localparam int MAX_DATA_WIDTH = 1024;
    localparam logic [MAX_DATA_WIDTH-1:0] ZERO_WORD = '0;

    function automatic int lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks every address once after reset, issuing a zero write
// per cycle, then parks in READY.
//   clk, rst        : clock, asynchronous active-high reset
//   busy            : high while the clear walk is in progress
//   clr_we          : write-zero strobe for the array
//   clr_addr        : address being cleared this cycle
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam ram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    ram_state_t            state_reg;
    ram_state_t            state_next;
    logic [ADDR_WIDTH-1:0] counter_reg;
    logic [ADDR_WIDTH-1:0] counter_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RESET_STATE;
            counter_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        busy         = 1'b0;
        clr_we       = 1'b0;
        clr_addr     = counter_reg;
        case (state_reg)
            CLEAR: begin
                busy         = 1'b1;
                clr_we       = 1'b1;
                counter_next = counter_reg + ADDR_WIDTH'(1);
                // Last address written this cycle: leave on the same edge.
                if (&counter_reg) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

endmodule

// File: rtl/ram_dp.sv
// ram_dp: dual-port synchronous RAM. Port A read/write with byte lanes,
// port B read-only; both reads registered with a one-cycle valid pulse.
//   clk, rst                 : clock, asynchronous active-high reset
//   a_en/a_we/a_be/a_addr/a_wdata : port A request
//   a_rdata/a_rvalid         : port A registered read data and strobe
//   b_en/b_addr              : port B read request
//   b_rdata/b_rvalid         : port B registered read data and strobe
//   busy                     : post-reset clear in progress; requests ignored
module ram_dp
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_en,
    input  logic                          a_we,
    input  logic [lanes(DATA_WIDTH)-1:0]  a_be,
    input  logic [ADDR_WIDTH-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0]         a_wdata,
    output logic [DATA_WIDTH-1:0]         a_rdata,
    output logic                          a_rvalid,
    input  logic                          b_en,
    input  logic [ADDR_WIDTH-1:0]         b_addr,
    output logic [DATA_WIDTH-1:0]         b_rdata,
    output logic                          b_rvalid,
    output logic                          busy
);

    localparam int LANES = lanes(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ZERO = ZERO_WORD[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  a_wr;
    logic                  a_rd;
    logic                  b_rd;
    logic                  collide;
    logic [DATA_WIDTH-1:0] b_word;

    ram_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign a_wr    = !busy && a_en && a_we;
    assign a_rd    = !busy && a_en && !a_we;
    assign b_rd    = !busy && b_en;
    assign collide = a_wr && (a_addr == b_addr);

    // Write-first view for port B: lanes being written this cycle are taken
    // from the write data, the rest from the stored word.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_b_fwd
        assign b_word[8*gi +: 8] = (collide && a_be[gi]) ? a_wdata[8*gi +: 8]
                                                         : mem[b_addr][8*gi +: 8];
    end

    // Array write port: clear walk has priority (requests are gated by busy
    // anyway), otherwise per-lane merge of port A data.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= ZERO;
        end else if (a_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata  <= ZERO;
            a_rvalid <= 1'b0;
            b_rdata  <= ZERO;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_rd;
            b_rvalid <= b_rd;
            if (a_rd) begin
                a_rdata <= mem[a_addr];
            end
            if (b_rd) begin
                b_rdata <= b_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp.sv
// tb_ram_dp: directed self-checking bench for ram_dp (16-bit words, 16 deep).
// A second instance with CLEAR_ON_RESET=0 shares all inputs and is used for
// the contents-retained-across-reset check.
module tb_ram_dp;

    logic        clk;
    logic        rst;
    logic        a_en;
    logic        a_we;
    logic [1:0]  a_be;
    logic [3:0]  a_addr;
    logic [15:0] a_wdata;
    logic [15:0] a_rdata;
    logic        a_rvalid;
    logic        b_en;
    logic [3:0]  b_addr;
    logic [15:0] b_rdata;
    logic        b_rvalid;
    logic        busy;

    logic [15:0] nc_a_rdata;
    logic        nc_a_rvalid;
    logic [15:0] nc_b_rdata;
    logic        nc_b_rvalid;
    logic        nc_busy;

    int checks = 0;
    int errors = 0;
    int n;

    ram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .busy(busy)
    );

    ram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(0)) dut_nc (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(nc_a_rdata), .a_rvalid(nc_a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(nc_b_rdata), .b_rvalid(nc_b_rvalid),
        .busy(nc_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        a_en = 1'b0; a_we = 1'b0; a_be = 2'b00; b_en = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
        a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_be = be;
        tick;
        idle;
        chk("wr_no_rvalid", a_rvalid, 0);
    endtask

    task automatic rd_a(input logic [3:0] addr);
        a_en = 1'b1; a_we = 1'b0; a_addr = addr;
        tick;
        idle;
    endtask

    // Ticks until busy drops, bounded; returns the number of ticks taken.
    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (busy && cnt < 64) begin
            tick;
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; idle; a_addr = '0; a_wdata = '0; b_addr = '0;
        tick; tick;
        chk("rst_busy", busy, 1);
        chk("rst_nc_busy", nc_busy, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 16'h0000);
        chk("rst_b_rdata", b_rdata, 16'h0000);
        rst = 1'b0;
        wait_clear(n);
        chk("first_clear_len", n, 16);

        // Pre-fill, then reset and confirm the whole array is zeroed.
        for (int i = 0; i < 16; i++) wr(4'(i), 16'hBEEF, 2'b11);
        rd_a(4'd7);
        chk("prefill_rd7", a_rdata, 16'hBEEF);
        rst = 1'b1;
        tick; tick;
        chk("rst2_busy", busy, 1);
        rst = 1'b0;
        wait_clear(n);
        chk("clear_len", n, 16);
        chk("busy_fall_a_rvalid", a_rvalid, 0);
        chk("busy_fall_b_rvalid", b_rvalid, 0);
        for (int i = 0; i < 16; i++) begin
            b_en = 1'b1; b_addr = 4'(i);
            tick;
            b_en = 1'b0;
            chk($sformatf("clr_b_rvalid_%0d", i), b_rvalid, 1);
            chk($sformatf("clr_b_rdata_%0d", i), b_rdata, 16'h0000);
        end
        tick;
        chk("b_rvalid_pulse", b_rvalid, 0);

        // Write / read on both ports.
        wr(4'd0, 16'h1212, 2'b11);
        wr(4'd1, 16'h3434, 2'b11);
        wr(4'hB, 16'h5656, 2'b11);
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd0; b_en = 1'b1; b_addr = 4'hB;
        tick;
        idle;
        chk("wr_a_rdata", a_rdata, 16'h1212);
        chk("wr_b_rdata", b_rdata, 16'h5656);
        chk("wr_a_rvalid", a_rvalid, 1);
        chk("wr_b_rvalid", b_rvalid, 1);
        tick;
        chk("hold_a_rvalid", a_rvalid, 0);
        chk("hold_b_rvalid", b_rvalid, 0);
        chk("hold_a_rdata", a_rdata, 16'h1212);
        chk("hold_b_rdata", b_rdata, 16'h5656);
        rd_a(4'd1);
        chk("rd_addr1", a_rdata, 16'h3434);

        // Byte lanes.
        wr(4'd3, 16'hABCD, 2'b11);
        wr(4'd3, 16'h00EF, 2'b01);
        wr(4'd3, 16'h7700, 2'b00);
        rd_a(4'd3);
        chk("lanes_rd3", a_rdata, 16'hABEF);

        // Collision: write-first on port B.
        wr(4'd5, 16'h1111, 2'b11);
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 16'h5A5A; a_be = 2'b10;
        b_en = 1'b1; b_addr = 4'd5;
        tick;
        idle;
        chk("coll_b_rdata", b_rdata, 16'h5A11);
        chk("coll_b_rvalid", b_rvalid, 1);
        chk("coll_a_rvalid", a_rvalid, 0);
        rd_a(4'd5);
        chk("coll_rd5", a_rdata, 16'h5A11);
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd5; b_en = 1'b1; b_addr = 4'd5;
        tick;
        idle;
        chk("same_addr_a", a_rdata, 16'h5A11);
        chk("same_addr_b", b_rdata, 16'h5A11);

        // Reset reasserted mid-clear, requests during busy ignored.
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        repeat (7) tick;
        chk("midclr_busy", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 16'hFFFF; a_be = 2'b11;
        b_en = 1'b1; b_addr = 4'd2;
        tick;
        idle;
        chk("busy_a_rvalid", a_rvalid, 0);
        chk("busy_b_rvalid", b_rvalid, 0);
        wait_clear(n);
        chk("midclr_len", n + 1, 16);
        rd_a(4'd2);
        chk("midclr_rd2", a_rdata, 16'h0000);
        rd_a(4'd5);
        chk("midclr_rd5", a_rdata, 16'h0000);

        // Top address and wrap; then retention without clear.
        wr(4'd15, 16'hFFFF, 2'b11);
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd15; b_en = 1'b1; b_addr = 4'd0;
        tick;
        idle;
        chk("wrap_rd15", a_rdata, 16'hFFFF);
        chk("wrap_rd0", b_rdata, 16'h0000);
        rst = 1'b1;
        tick;
        chk("ret_busy", busy, 1);
        chk("ret_nc_busy", nc_busy, 0);
        chk("ret_nc_rdata_rst", nc_b_rdata, 16'h0000);
        rst = 1'b0;
        b_en = 1'b1; b_addr = 4'd15;
        tick;
        idle;
        chk("ret_nc_busy_after", nc_busy, 0);
        chk("ret_nc_b_rvalid", nc_b_rvalid, 1);
        chk("ret_nc_b_rdata", nc_b_rdata, 16'hFFFF);
        chk("ret_b_rvalid_busy", b_rvalid, 0);
        wait_clear(n);
        chk("ret_clear_len", n + 1, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
